uart_fifo_ctrl: RTL and testbench

Memory-mapped UART peripheral with parametrised TX and RX FIFOs, status/control registers, overflow flags and an interrupt line. It is the successor to the single-byte, unbuffered CPU-to-UART bridge. It sits on the CPU data bus behind the external address decoder and wraps the existing `uart_rx` and `uart_tx` serial engines. The CPU can queue bursts of bytes and poll or take interrupts instead of busy-waiting per byte.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_fifo_ctrl_if.sv | 11 +
 rtl/uart_rx.sv | 73 +++++++
 rtl/uart_sync_fifo.sv | 48 ++++
 rtl/uart_tx.sv | 50 +++++
 rtl/uart_fifo_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 261 ++++++++++++++++++++++++++
 7 files changed

// File: rtl/uart_pkg.sv
// Shared register map, bit positions and TX FSM states for the buffered UART peripheral.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_RX_NEMPTY = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_FULL   = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_RX_OVF    = 5;
  localparam int ST_TX_OVF    = 6;
  localparam int ST_RX_BRK    = 7;

  localparam int CTRL_RX_EN      = 0;
  localparam int CTRL_TX_EN      = 1;
  localparam int CTRL_IRQ_RX_EN  = 2;
  localparam int CTRL_IRQ_TXE_EN = 3;

  localparam logic [3:0] CTRL_RESET = 4'h3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// CPU-side register bus of the UART peripheral; the address decoder has already qualified the strobes.
interface uart_fifo_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;

  modport master (output addr, wdata, wen, ren, input rdata);
  modport slave  (input addr, wdata, wen, ren, output rdata);
endinterface

// File: rtl/uart_rx.sv
// Serial receive engine: 8N1 frames sampled near bit centre, one-cycle valid pulse, break on an all-zero frame.
module uart_rx #(
  parameter int CLK_HZ       = 10_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rxd,
  output logic                    uart_rx_break,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CCW = $clog2(CPB + 1);
  localparam int IW  = $clog2(PAYLOAD_BITS + 2);

  logic                    rxd_meta;
  logic                    rxd_s;
  logic                    rxd_prev;
  logic                    active;
  logic [CCW-1:0]          cyc;
  logic [IW-1:0]           idx;
  logic [PAYLOAD_BITS-1:0] shreg;

  // idx 0 is the start bit, 1..PAYLOAD_BITS the data bits, the last one the stop bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_meta      <= 1'b1;
      rxd_s         <= 1'b1;
      rxd_prev      <= 1'b1;
      active        <= 1'b0;
      cyc           <= '0;
      idx           <= '0;
      shreg         <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
      uart_rx_data  <= '0;
    end else begin
      rxd_meta      <= uart_rxd;
      rxd_s         <= rxd_meta;
      rxd_prev      <= rxd_s;
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
      if (!active) begin
        if (rxd_prev && !rxd_s) begin
          active <= 1'b1;
          idx    <= '0;
          cyc    <= CCW'(CPB / 2);
        end
      end else if (cyc != '0) begin
        cyc <= cyc - 1'b1;
      end else begin
        cyc <= CCW'(CPB - 1);
        idx <= idx + 1'b1;
        if (idx == '0) begin
          if (rxd_s) active <= 1'b0;
        end else if (idx <= IW'(PAYLOAD_BITS)) begin
          shreg <= {rxd_s, shreg[PAYLOAD_BITS-1:1]};
        end else begin
          active <= 1'b0;
          if (rxd_s) begin
            uart_rx_valid <= 1'b1;
            uart_rx_data  <= shreg;
          end else if (shreg == '0) begin
            uart_rx_break <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop on a full FIFO frees room for a same-cycle push.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// Serial transmit engine: launches one 8N1 frame per uart_tx_en while idle; busy covers start through stop bit.
module uart_tx #(
  parameter int CLK_HZ       = 10_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CCW = $clog2(CPB + 1);
  localparam int BW  = $clog2(PAYLOAD_BITS + 2);

  logic [CCW-1:0]          cyc;
  logic [BW-1:0]           bits_left;
  logic [PAYLOAD_BITS-1:0] shreg;

  // The shift register back-fills ones so the final shifted-out bit is the stop bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
      cyc          <= '0;
      bits_left    <= '0;
      shreg        <= '0;
    end else if (!uart_tx_busy) begin
      if (uart_tx_en) begin
        uart_tx_busy <= 1'b1;
        uart_txd     <= 1'b0;
        shreg        <= uart_tx_data;
        bits_left    <= BW'(PAYLOAD_BITS + 1);
        cyc          <= CCW'(CPB - 1);
      end
    end else if (cyc != '0) begin
      cyc <= cyc - 1'b1;
    end else if (bits_left != '0) begin
      uart_txd  <= shreg[0];
      shreg     <= {1'b1, shreg[PAYLOAD_BITS-1:1]};
      bits_left <= bits_left - 1'b1;
      cyc       <= CCW'(CPB - 1);
    end else begin
      uart_tx_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Memory-mapped UART with TX/RX FIFOs, sticky error flags and a level interrupt,
// wrapping the uart_rx/uart_tx serial engines.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 10_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            uart_rxd,
  output logic            uart_txd,
  uart_fifo_ctrl_if.slave bus,
  output logic            irq
);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  logic [1:0]              sel;
  logic                    data_wr, status_wr, ctrl_wr, data_rd;
  logic [3:0]              ctrl;
  logic                    rx_ovf, tx_ovf, rx_brk;
  logic                    tx_push, tx_pop, tx_full, tx_empty;
  logic [PAYLOAD_BITS-1:0] tx_rdata;
  logic [TCW-1:0]          tx_count;
  logic                    rx_push, rx_pop, rx_full, rx_empty;
  logic [PAYLOAD_BITS-1:0] rx_rdata;
  logic [RCW-1:0]          rx_count;
  logic                    uart_rx_valid, uart_rx_break;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic                    uart_tx_busy, uart_tx_en;
  logic [PAYLOAD_BITS-1:0] tx_byte;
  tx_state_t               state, state_next;
  logic                    seen_busy;
  logic                    tx_busy;
  logic                    tx_drop, rx_drop;
  logic [31:0]             status;
  logic                    unused_bits;

  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:8]};

  assign sel       = bus.addr[3:2];
  assign data_wr   = bus.wen && (sel == REG_DATA);
  assign status_wr = bus.wen && (sel == REG_STATUS);
  assign ctrl_wr   = bus.wen && (sel == REG_CTRL);
  assign data_rd   = bus.ren && (sel == REG_DATA);

  assign tx_push = data_wr;
  assign rx_push = uart_rx_valid & ctrl[CTRL_RX_EN];
  assign rx_pop  = data_rd & ~rx_empty;
  // A byte is only lost when full and no same-cycle pop frees a slot
  assign tx_drop = tx_push & tx_full & ~tx_pop;
  assign rx_drop = rx_push & rx_full & ~rx_pop;
  assign tx_busy = (state != TX_IDLE) | uart_tx_busy;

  uart_sync_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop),
    .wdata(bus.wdata[PAYLOAD_BITS-1:0]), .rdata(tx_rdata),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_sync_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop),
    .wdata(uart_rx_data), .rdata(rx_rdata),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PAYLOAD_BITS)) u_uart_rx (
    .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd), .uart_rx_break(uart_rx_break),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data)
  );

  uart_tx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PAYLOAD_BITS)) u_uart_tx (
    .clk(clk), .rst_n(rst_n), .uart_txd(uart_txd), .uart_tx_busy(uart_tx_busy),
    .uart_tx_en(uart_tx_en), .uart_tx_data(tx_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= TX_IDLE;
      seen_busy <= 1'b0;
      tx_byte   <= '0;
    end else begin
      state <= state_next;
      if (tx_pop) tx_byte <= tx_rdata;
      if (state != TX_WAIT)  seen_busy <= 1'b0;
      else if (uart_tx_busy) seen_busy <= 1'b1;
    end
  end

  // WAIT must see the engine go busy before trusting a low busy as frame done
  always_comb begin
    state_next = state;
    tx_pop     = 1'b0;
    uart_tx_en = 1'b0;
    case (state)
      TX_IDLE: begin
        if (ctrl[CTRL_TX_EN] && !tx_empty && !uart_tx_busy) begin
          state_next = TX_LOAD;
          tx_pop     = 1'b1;
        end
      end
      TX_LOAD: begin
        uart_tx_en = 1'b1;
        state_next = TX_WAIT;
      end
      TX_WAIT: begin
        if (seen_busy && !uart_tx_busy) state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    status                = '0;
    status[ST_RX_NEMPTY]  = ~rx_empty;
    status[ST_RX_FULL]    = rx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_BUSY]    = tx_busy;
    status[ST_RX_OVF]     = rx_ovf;
    status[ST_TX_OVF]     = tx_ovf;
    status[ST_RX_BRK]     = rx_brk;
    status[15:8]          = 8'(rx_count);
    status[23:16]         = 8'(tx_count);
  end

  // Sticky flags: a same-cycle set overrides a write-one-to-clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl      <= CTRL_RESET;
      rx_ovf    <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_brk    <= 1'b0;
      irq       <= 1'b0;
      bus.rdata <= '0;
    end else begin
      if (ctrl_wr) ctrl <= bus.wdata[3:0];
      rx_ovf <= rx_drop | (rx_ovf & ~(status_wr & bus.wdata[ST_RX_OVF]));
      tx_ovf <= tx_drop | (tx_ovf & ~(status_wr & bus.wdata[ST_TX_OVF]));
      rx_brk <= uart_rx_break | (rx_brk & ~(status_wr & bus.wdata[ST_RX_BRK]));
      irq    <= (ctrl[CTRL_IRQ_RX_EN] & ~rx_empty)
              | (ctrl[CTRL_IRQ_TXE_EN] & tx_empty & ~tx_busy)
              | rx_ovf | tx_ovf;
      if (bus.ren) begin
        case (sel)
          REG_DATA:   bus.rdata <= rx_empty ? 32'h0 : 32'(rx_rdata);
          REG_STATUS: bus.rdata <= status;
          REG_CTRL:   bus.rdata <= {28'h0, ctrl};
          default:    bus.rdata <= 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: bus reads and serial TX frames are queued as expectations
// and checked by independent monitor processes.
module tb_uart_fifo_ctrl;
  import uart_pkg::*;

  localparam int CPB = 10;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rxd = 1'b1;
  logic uart_txd;
  logic irq;

  exp_t       rdExp[$];
  logic [7:0] txExp[$];
  exp_t       curExp;
  int         checks = 0;
  int         passes = 0;
  int         txFrames = 0;
  int         framesBefore;
  logic       rdPend = 1'b0;

  uart_fifo_ctrl_if bus();

  uart_fifo_ctrl #(
    .CLK_HZ(10_000_000), .BIT_RATE(1_000_000), .PAYLOAD_BITS(8),
    .TX_DEPTH(16), .RX_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .bus(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic wen, input logic ren, input logic [1:0] regSel,
                               input logic [31:0] wdata, input string name, input logic [31:0] exp);
    exp_t e;
    bus.addr  = {28'h0, regSel, 2'b00};
    bus.wdata = wdata;
    bus.wen   = wen;
    bus.ren   = ren;
    if (ren) begin
      e.name  = name;
      e.value = exp;
      rdExp.push_back(e);
    end
    @(negedge clk);
    bus.wen = 1'b0;
    bus.ren = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] regSel, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, regSel, d, "", 32'h0);
  endtask

  task automatic readReg(input logic [1:0] regSel, input string name, input logic [31:0] exp);
    applyStimulus(1'b0, 1'b1, regSel, 32'h0, name, exp);
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stopBit);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
    uart_rxd = stopBit;
    tick(CPB);
    uart_rxd = 1'b1;
    tick(CPB);
  endtask

  task automatic waitFrames(input int n, input int limit);
    for (int i = 0; i < limit && txFrames < n; i++) @(negedge clk);
    checkOutput("tx_frames", txFrames, n);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    txExp.delete();
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Read data appears the cycle after the strobe
  always @(posedge clk) rdPend <= bus.ren && rst_n;

  always @(negedge clk) begin
    if (rdPend) begin
      if (rdExp.size() == 0) begin
        checks++;
        $display("[TB] FAIL rd_unexpected: got 0x%08h, expected no read data", bus.rdata);
      end else begin
        curExp = rdExp.pop_front();
        checkOutput(curExp.name, bus.rdata, curExp.value);
      end
    end
  end

  // Decodes frames on uart_txd; a frame overlapped by reset is discarded
  initial begin : lineMon
    logic [7:0] b;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (rst_n && uart_txd == 1'b0) begin
        aborted = 1'b0;
        b = 8'h0;
        for (int c = 1; c <= 95; c++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          if (c >= 15 && c <= 85 && (c - 15) % 10 == 0) b[(c - 15) / 10] = uart_txd;
        end
        if (!aborted) begin
          txFrames++;
          checkOutput("tx_stop_bit", {31'h0, uart_txd}, 32'h1);
          if (txExp.size() == 0) begin
            checks++;
            $display("[TB] FAIL tx_unexpected_frame: got 0x%02h, expected no frame", b);
          end else begin
            checkOutput("tx_byte", {24'h0, b}, {24'h0, txExp.pop_front()});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : main
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    bus.wen   = 1'b0;
    bus.ren   = 1'b0;
    @(negedge clk);
    doReset();

    // Reset values
    checkOutput("rst_txd", {31'h0, uart_txd}, 32'h1);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    readReg(REG_STATUS, "rst_status", 32'h0000_0004);
    readReg(REG_CTRL, "rst_ctrl", 32'h0000_0003);
    writeReg(2'd3, 32'hFFFF_FFFF);
    readReg(2'd3, "reserved_rd", 32'h0);
    readReg(REG_CTRL, "ctrl_after_rsv_wr", 32'h0000_0003);

    // TX ordering
    writeReg(REG_CTRL, 32'h1);
    writeReg(REG_DATA, 32'h41); txExp.push_back(8'h41);
    writeReg(REG_DATA, 32'h42); txExp.push_back(8'h42);
    writeReg(REG_DATA, 32'h43); txExp.push_back(8'h43);
    readReg(REG_STATUS, "tx_count3", 32'h0003_0000);
    writeReg(REG_CTRL, 32'h3);
    tick(4);
    readReg(REG_STATUS, "tx_count2_busy", 32'h0002_0010);
    waitFrames(3, 1000);
    tick(20);
    readReg(REG_STATUS, "tx_done", 32'h0000_0004);
    writeReg(REG_CTRL, 32'hB);
    tick(3);
    checkOutput("irq_txe", {31'h0, irq}, 32'h1);
    writeReg(REG_CTRL, 32'h3);
    tick(3);
    checkOutput("irq_txe_off", {31'h0, irq}, 32'h0);
    applyStimulus(1'b1, 1'b1, REG_DATA, 32'h5A, "rd_empty_with_wr", 32'h0);
    txExp.push_back(8'h5A);
    waitFrames(4, 400);
    tick(20);

    // TX overflow
    writeReg(REG_CTRL, 32'h1);
    for (int i = 0; i < 17; i++) writeReg(REG_DATA, 32'h60 + i);
    readReg(REG_STATUS, "tx_ovf", 32'h0010_0048);
    tick(2);
    checkOutput("irq_tx_ovf", {31'h0, irq}, 32'h1);
    writeReg(REG_STATUS, 32'h40);
    readReg(REG_STATUS, "tx_ovf_clr", 32'h0010_0008);
    tick(2);
    checkOutput("irq_tx_ovf_clr", {31'h0, irq}, 32'h0);
    doReset();
    readReg(REG_STATUS, "post_ovf_rst", 32'h0000_0004);

    // RX loopback
    writeReg(REG_CTRL, 32'h7);
    sendRx(8'hA5, 1'b1);
    sendRx(8'h3C, 1'b1);
    readReg(REG_STATUS, "rx_count2", 32'h0000_0205);
    checkOutput("irq_rx", {31'h0, irq}, 32'h1);
    readReg(REG_DATA, "rx_byte0", 32'h0000_00A5);
    readReg(REG_DATA, "rx_byte1", 32'h0000_003C);
    readReg(REG_DATA, "rx_empty_rd", 32'h0);
    tick(2);
    checkOutput("irq_rx_off", {31'h0, irq}, 32'h0);

    // RX disabled, then break detection
    writeReg(REG_CTRL, 32'h2);
    sendRx(8'h99, 1'b1);
    readReg(REG_STATUS, "rx_disabled", 32'h0000_0004);
    writeReg(REG_CTRL, 32'h3);
    sendRx(8'h00, 1'b0);
    readReg(REG_STATUS, "rx_brk", 32'h0000_0084);
    writeReg(REG_STATUS, 32'h80);
    readReg(REG_STATUS, "rx_brk_clr", 32'h0000_0004);

    // RX overflow
    writeReg(REG_CTRL, 32'h1);
    for (int k = 0; k < 17; k++) sendRx(8'h10 + 8'(k), 1'b1);
    readReg(REG_STATUS, "rx_ovf", 32'h0000_1027);
    tick(1);
    checkOutput("irq_rx_ovf", {31'h0, irq}, 32'h1);
    for (int k = 0; k < 16; k++) readReg(REG_DATA, "rx_ovf_data", 32'h10 + k);
    readReg(REG_DATA, "rx_ovf_drained", 32'h0);
    writeReg(REG_STATUS, 32'h20);
    readReg(REG_STATUS, "rx_ovf_clr", 32'h0000_0004);

    // Reset in the middle of a frame
    writeReg(REG_CTRL, 32'h1);
    for (int i = 0; i < 4; i++) writeReg(REG_DATA, 32'h71 + i);
    writeReg(REG_CTRL, 32'h3);
    tick(30);
    framesBefore = txFrames;
    rst_n = 1'b0;
    tick(1);
    checkOutput("rst_mid_txd", {31'h0, uart_txd}, 32'h1);
    checkOutput("rst_mid_rdata", bus.rdata, 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    readReg(REG_STATUS, "rst_mid_status", 32'h0000_0004);
    tick(400);
    checkOutput("no_frames_after_rst", txFrames, framesBefore);

    tick(5);
    checkOutput("tx_pending", txExp.size(), 32'h0);
    checkOutput("rd_pending", rdExp.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
